// File: rtl/dac_sample_feeder_if.sv
// Sample stream into the DAC feeder: signed 16-bit PCM over valid/ready.
interface dac_sample_feeder_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_sample_feeder.sv
// Buffers PCM samples in a small FIFO and releases one per sample period to
// the delta-sigma DAC as an offset-binary word; parks at mid-scale when idle.
module dac_sample_feeder #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  enable,
  input  logic [DIV_W-1:0]      rate_div,
  dac_sample_feeder_if.slave    stream,
  output logic [15:0]           dac_word,
  output logic                  sample_strobe,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam logic [15:0] MID_SCALE = 16'h8000;

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DIV_W-1:0] cnt;
  logic [15:0]      head;
  logic             empty;
  logic             push;
  logic             tick;
  logic             pop;

  // Extra pointer bit makes the difference a full 0..DEPTH count.
  assign fifo_level     = wr_ptr - rd_ptr;
  assign empty          = (fifo_level == '0);
  assign stream.s_ready = (fifo_level != PTR_W'(DEPTH));
  assign push           = stream.s_valid && stream.s_ready;
  assign tick           = enable && (cnt >= rate_div);
  assign pop            = tick && !empty;
  assign head           = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= stream.s_data;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Greater-or-equal compare so a lowered rate_div takes effect at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dac_word      <= MID_SCALE;
      sample_strobe <= 1'b0;
    end else if (!enable) begin
      dac_word      <= MID_SCALE;
      sample_strobe <= 1'b0;
    end else if (pop) begin
      dac_word      <= {~head[15], head[14:0]};
      sample_strobe <= 1'b1;
    end else begin
      sample_strobe <= 1'b0;
    end
  end

  // An empty tick outranks a simultaneous clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      underrun <= 1'b0;
    end else if (tick && empty) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Bench for dac_sample_feeder: vector table plus scoreboard of expected DAC codes.
module tb_dac_sample_feeder;

  logic        Clk;
  logic        Reset;
  logic        enable;
  logic [15:0] rate_div;
  logic [15:0] dac_word;
  logic        sample_strobe;
  logic [4:0]  fifo_level;
  logic        underrun;
  logic        underrun_clr;

  dac_sample_feeder_if bus ();

  dac_sample_feeder #(.DEPTH_LOG2(4), .DIV_W(16)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .enable        (enable),
    .rate_div      (rate_div),
    .stream        (bus),
    .dac_word      (dac_word),
    .sample_strobe (sample_strobe),
    .fifo_level    (fifo_level),
    .underrun      (underrun),
    .underrun_clr  (underrun_clr)
  );

  typedef struct {
    logic [15:0] sample;
    logic [15:0] code;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] sb [$];
  int          tests_run;
  int          tests_failed;
  int          cyc;
  int          last_cyc;
  int          exp_period;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_one(input logic [15:0] d, input logic [15:0] code);
    logic acc;
    logic accepted;
    accepted    = 1'b0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge Clk);
      acc = bus.s_ready;
      @(posedge Clk);
      if (acc) begin
        sb.push_back(code);
        accepted = 1'b1;
      end
    end
    #1;
    bus.s_valid = 1'b0;
    check("push_accept", 32'(accepted), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic park_and_clear();
    enable = 1'b0;
    @(posedge Clk); #1;
    check("park_mid_scale", 32'(dac_word), 32'h8000);
    underrun_clr = 1'b1;
    @(posedge Clk); #1;
    underrun_clr = 1'b0;
    check("underrun_cleared", 32'(underrun), 32'd0);
    exp_period = 0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    last_cyc     = -1;
    exp_period   = 0;
    Reset        = 1'b1;
    enable       = 1'b0;
    rate_div     = 16'd3;
    underrun_clr = 1'b0;
    bus.s_data   = '0;
    bus.s_valid  = 1'b0;

    vecs[0] = '{16'h0000, 16'h8000};
    vecs[1] = '{16'h7FFF, 16'hFFFF};
    vecs[2] = '{16'h8000, 16'h0000};
    vecs[3] = '{16'hFFFF, 16'h7FFF};
    vecs[4] = '{16'h1234, 16'h9234};
    vecs[5] = '{16'h8001, 16'h0001};

    // Scoreboard monitor: every strobe must match the oldest expected code.
    fork
      forever begin
        @(negedge Clk);
        cyc++;
        if (!Reset && sample_strobe) begin
          check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) check("dac_word", 32'(dac_word), 32'(sb.pop_front()));
          if (exp_period != 0 && last_cyc >= 0) check("strobe_period", 32'(cyc - last_cyc), 32'(exp_period));
          last_cyc = cyc;
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_dac_word", 32'(dac_word), 32'h8000);
    check("rst_strobe", 32'(sample_strobe), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    check("rst_ready", 32'(bus.s_ready), 32'd1);

    // 1: table samples at rate_div = 3
    for (int i = 0; i < 6; i++) begin
      push_one(vecs[i].sample, vecs[i].code);
      check("t1_level", 32'(fifo_level), 32'(i + 1));
    end
    exp_period = 4;
    last_cyc   = -1;
    enable     = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge Clk);
      check("t1_first_tick", 32'(sample_strobe), 32'(k == 4));
    end
    wait_drain(100);
    park_and_clear();

    // 2: fill to full while disabled, then play out
    for (int i = 0; i < 16; i++) push_one(16'(i * 16'h1111), 16'(i * 16'h1111) ^ 16'h8000);
    check("t2_level_full", 32'(fifo_level), 32'd16);
    check("t2_ready_full", 32'(bus.s_ready), 32'd0);
    check("t2_dac_parked", 32'(dac_word), 32'h8000);
    bus.s_data  = 16'hABCD;
    bus.s_valid = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    bus.s_valid = 1'b0;
    check("t2_no_overflow", 32'(fifo_level), 32'd16);
    rate_div   = 16'd1;
    exp_period = 2;
    last_cyc   = -1;
    enable     = 1'b1;
    wait_drain(200);
    park_and_clear();

    // 3: underrun set, clear-vs-set priority, then clear
    push_one(16'h1357, 16'h9357);
    rate_div = 16'd0;
    enable   = 1'b1;
    @(negedge Clk);
    check("t3_underrun_before", 32'(underrun), 32'd0);
    repeat (2) @(negedge Clk);
    check("t3_underrun_set", 32'(underrun), 32'd1);
    check("t3_dac_holds", 32'(dac_word), 32'h9357);
    check("t3_no_strobe", 32'(sample_strobe), 32'd0);
    @(posedge Clk); #1;
    underrun_clr = 1'b1;
    @(posedge Clk); #1;
    underrun_clr = 1'b0;
    check("t3_set_wins", 32'(underrun), 32'd1);
    park_and_clear();

    // 4: lowering rate_div mid-count ticks immediately
    for (int i = 0; i < 4; i++) push_one(16'(16'h0400 + i), 16'(16'h0400 + i) ^ 16'h8000);
    rate_div = 16'd9;
    enable   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      check("t4_no_early_tick", 32'(sample_strobe), 32'd0);
    end
    rate_div = 16'd5;
    @(negedge Clk);
    check("t4_immediate_tick", 32'(sample_strobe), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      check("t4_period6", 32'(sample_strobe), 32'(k == 6));
    end
    wait_drain(100);
    park_and_clear();

    // 5: streaming push+pop at level 5 across pointer wrap
    for (int i = 0; i < 5; i++) push_one(16'(16'h0500 + i), 16'(16'h0500 + i) ^ 16'h8000);
    rate_div   = 16'd0;
    exp_period = 1;
    last_cyc   = -1;
    enable     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      d           = 16'($urandom);
      bus.s_data  = d;
      bus.s_valid = 1'b1;
      @(negedge Clk);
      check("t5_level", 32'(fifo_level), 32'd5);
      check("t5_ready", 32'(bus.s_ready), 32'd1);
      @(posedge Clk);
      sb.push_back(d ^ 16'h8000);
      #1;
    end
    bus.s_valid = 1'b0;
    wait_drain(50);
    park_and_clear();

    // 6: asynchronous reset mid-period flushes the FIFO
    for (int i = 0; i < 9; i++) push_one(16'(16'h0100 + i), 16'(16'h0100 + i) ^ 16'h8000);
    rate_div = 16'd3;
    enable   = 1'b1;
    repeat (7) @(negedge Clk);
    check("t6_level8", 32'(fifo_level), 32'd8);
    check("t6_dac_live", 32'(dac_word), 32'h8100);
    #2;
    Reset = 1'b1;
    #1;
    sb.delete();
    check("t6_rst_dac", 32'(dac_word), 32'h8000);
    check("t6_rst_level", 32'(fifo_level), 32'd0);
    check("t6_rst_underrun", 32'(underrun), 32'd0);
    check("t6_rst_strobe", 32'(sample_strobe), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    check("t6_ready", 32'(bus.s_ready), 32'd1);
    for (int k = 0; k <= 4; k++) begin
      @(negedge Clk);
      check("t6_flushed_underrun", 32'(underrun), 32'(k == 4));
    end
    enable = 1'b0;
    repeat (2) @(posedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dac_sample_feeder.md
Name: dac_sample_feeder

Overview:
Upstream stage of the delta-sigma DAC. It accepts signed 16-bit PCM samples over a valid/ready stream and buffers them in a small FIFO. It releases one sample per programmable sample period and converts it to excess-2^15 (offset binary) on dac_word, which drives the DAC's 16-bit input directly. It also handles the idle and underrun cases so the DAC never sees an undefined code.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16)
DIV_W, 16, width of rate_div sample-period divider

Ports:
Clk  in  1  system clock (same clock as DAC)
Reset  in  1  asynchronous, active-high reset
enable  in  1  1 = playback running; 0 = output parked at mid-scale
rate_div  in  DIV_W  sample period minus one, in Clk cycles
s_data  in  16  signed two's-complement sample
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept; = not full
dac_word  out  16  excess-2^15 code to DAC input (registered)
sample_strobe  out  1  one-cycle pulse, high in the cycle dac_word shows a newly popped sample (registered)
fifo_level  out  DEPTH_LOG2+1  current entry count, 0..2**DEPTH_LOG2
underrun  out  1  sticky flag: a tick found the FIFO empty
underrun_clr  in  1  synchronous clear of underrun

Behaviour:
- Reset values:
  - dac_word = 16'h8000; sample_strobe = 0; underrun = 0; fifo_level = 0.
  - FIFO pointers = 0; divider counter = 0.
  - s_ready = 1 once Reset deasserts, because the FIFO is empty.
- Write side:
  - Push when s_valid && s_ready on a rising Clk edge.
  - s_ready = (fifo_level != DEPTH); it is combinational from registered state only.
  - No bypass: when full, s_ready stays 0 even if a pop occurs in the same cycle.
  - FIFO accepts writes regardless of enable.
- Divider:
  - Counter cnt increments each cycle while enable = 1.
  - Internal tick when cnt >= rate_div; on a tick, cnt <= 0.
  - Sample period is therefore rate_div+1 cycles; rate_div = 0 gives a tick every cycle.
  - The >= compare ensures that lowering rate_div mid-count ticks on the next cycle, with no long wrap.
- On a tick with FIFO non-empty:
  - Pop the head entry.
  - dac_word <= {~d[15], d[14:0]}.
  - sample_strobe <= 1.
  - Latency: a sample pushed into an empty FIFO is visible on dac_word no earlier than the cycle after the next tick edge.
- On a tick with FIFO empty:
  - dac_word holds its last value; sample_strobe <= 0; underrun <= 1.
  - A push in the same cycle as that tick is not bypassed; it is consumed at the following tick.
- Simultaneous push and pop (non-empty, non-full): both occur; fifo_level is unchanged.
- underrun:
  - Set by an empty tick.
  - underrun_clr clears it.
  - If set and clear happen in the same cycle, set wins.
- enable = 0:
  - cnt <= 0 and no ticks occur.
  - dac_word <= 16'h8000 on the next edge; sample_strobe <= 0.
  - FIFO contents and underrun are retained.
- enable rising:
  - The first tick occurs rate_div+1 cycles after the first cycle with enable = 1.
  - dac_word stays at 8000 until that tick.
- Reset mid-operation: all state returns to reset values asynchronously and FIFO contents are discarded.
- fifo_level is always consistent with the pointers; pointers wrap modulo DEPTH. An extra pointer bit distinguishes full from empty.

Test Plan:
1. Reset, enable = 1, rate_div = 3, push 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF → dac_word sequence 8000, FFFF, 0000, 7FFF, one change every 4 cycles, each with a single-cycle sample_strobe.
2. Push 16 samples with enable = 0 → s_ready = 0 after the 16th push, fifo_level = 16, dac_word = 8000. Hold s_valid on a 17th value → it is not accepted. Set enable = 1 → 16 samples emitted in order.
3. rate_div = 0 with FIFO empty → underrun = 1 after the first tick and dac_word holds. Pulse underrun_clr on a cycle where a tick also finds the FIFO empty → underrun stays 1. Pulse underrun_clr with no tick → underrun = 0.
4. rate_div = 9 and cnt = 7, write rate_div = 5 → tick on the next cycle, then every 6 cycles.
5. Steady state with push and pop in the same cycle at level 5 → fifo_level stays 5 and data order is preserved across pointer wrap; run 40 samples with no loss or duplication.
6. Assert Reset asynchronously mid-period with level 8 → outputs return to reset values immediately. After release, the first tick with enable = 1 gives underrun = 1 because the FIFO was flushed.
